// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and limits for the backing-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Largest supported fixed memory latency (cycles from enable to data).
    localparam int MAX_MEM_LATENCY = 15;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way round-robin arbiter. Grant is combinational from the
//                requests; the last-owner pointer advances only on accept.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_ifetch,
    input  logic i_req_dcache,
    input  logic i_accept,
    output logic o_gnt_ifetch,
    output logic o_gnt_dcache
);

    owner_t last_owner_q;
    owner_t last_owner_d;

    // Grant: a lone requester wins; on a tie the side that did not win last time wins.
    always_comb begin
        o_gnt_ifetch = 1'b0;
        o_gnt_dcache = 1'b0;
        if (i_req_ifetch && i_req_dcache) begin
            if (last_owner_q == OWNER_D) begin
                o_gnt_ifetch = 1'b1;
            end else begin
                o_gnt_dcache = 1'b1;
            end
        end else begin
            o_gnt_ifetch = i_req_ifetch;
            o_gnt_dcache = i_req_dcache;
        end
    end

    // Next owner pointer: follows the winner of an accepted grant.
    always_comb begin
        last_owner_d = last_owner_q;
        if (i_accept) begin
            last_owner_d = o_gnt_dcache ? OWNER_D : OWNER_I;
        end
    end

    // Owner pointer register; reset to D so the first tie goes to I.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWNER_D;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/backing_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : backing_mem_arbiter
//  Description : Shares a single-ported fixed-latency backing memory between
//                the instruction-fetch (I) and data-cache (D) requesters.
//  Revision    : 1.0 - initial release
// ============================================================================
module backing_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    // Latency outside 1..MAX_MEM_LATENCY is clamped into range.
    localparam int c_LAT = (MEM_LATENCY < 1) ? 1 :
                           (MEM_LATENCY > MAX_MEM_LATENCY) ? MAX_MEM_LATENCY : MEM_LATENCY;
    localparam int c_CNT_W = $clog2(c_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(c_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    arb_state_t           state_q, state_d;
    owner_t               owner_q, owner_d;
    logic                 we_q, we_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;

    logic w_idle;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_accept;
    logic w_resp;

    // Grants are only possible in IDLE and never while reset is held.
    assign w_idle   = (state_q == ARB_IDLE) && rst;
    assign w_accept = w_gnt_i | w_gnt_d;

    rr_arbiter2 u_rr (
        .clk          (clk),
        .rst          (rst),
        .i_req_ifetch (i_req & w_idle),
        .i_req_dcache (d_req & w_idle),
        .i_accept     (w_accept),
        .o_gnt_ifetch (w_gnt_i),
        .o_gnt_dcache (w_gnt_d)
    );

    // Next-state: latch owner/op on grant, count down the fixed latency, respond once.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_accept) begin
                    owner_d = w_gnt_d ? OWNER_D : OWNER_I;
                    we_d    = w_gnt_d & d_we;
                    cnt_d   = c_CNT_LOAD;
                    state_d = (c_LAT > 1) ? ARB_WAIT : ARB_RESP;
                end
            end
            ARB_WAIT: begin
                cnt_d = cnt_q - c_CNT_ONE;
                if (cnt_q == c_CNT_ONE) begin
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWNER_D;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory-side drive: only in the grant cycle, zero otherwise.
    always_comb begin
        i_gnt     = w_gnt_i;
        d_gnt     = w_gnt_d;
        mem_en    = w_accept;
        mem_we    = w_gnt_d & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_gnt_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_gnt_i) begin
            mem_addr  = i_addr;
        end
    end

    // Response routing: read data passes straight through to the owner only.
    always_comb begin
        w_resp   = (state_q == ARB_RESP);
        i_rvalid = w_resp && (owner_q == OWNER_I);
        d_rvalid = w_resp && (owner_q == OWNER_D);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = (d_rvalid && !we_q) ? mem_rdata : '0;
        busy     = (state_q != ARB_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_backing_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_backing_mem_arbiter
//  Description : Bench for backing_mem_arbiter; one instance with latency 2
//                and one with latency 1 run side by side against a
//                cycle-accounting reference model and a latency-line memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_backing_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       i_req, i_gnt, i_rvalid;
    logic [1:0]       d_req, d_we, d_gnt, d_rvalid;
    logic [1:0]       mem_en, mem_we, busy;
    logic [1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

    generate
        for (genvar k = 0; k < 2; k++) begin : g_dut
            backing_mem_arbiter #(
                .ADDR_WIDTH  (32),
                .DATA_WIDTH  (32),
                .MEM_LATENCY ((k == 0) ? 2 : 1)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .i_req     (i_req[k]),
                .i_addr    (i_addr[k]),
                .i_gnt     (i_gnt[k]),
                .i_rvalid  (i_rvalid[k]),
                .i_rdata   (i_rdata[k]),
                .d_req     (d_req[k]),
                .d_we      (d_we[k]),
                .d_addr    (d_addr[k]),
                .d_wdata   (d_wdata[k]),
                .d_gnt     (d_gnt[k]),
                .d_rvalid  (d_rvalid[k]),
                .d_rdata   (d_rdata[k]),
                .mem_en    (mem_en[k]),
                .mem_we    (mem_we[k]),
                .mem_addr  (mem_addr[k]),
                .mem_wdata (mem_wdata[k]),
                .mem_rdata (mem_rdata[k]),
                .busy      (busy[k])
            );
        end
    endgenerate

    function automatic int lat(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    // Power-on memory contents; word 0x100 holds the known pattern.
    function automatic logic [31:0] init_val(int idx);
        if (idx == 64) return 32'hDEADBEEF;
        return 32'h5A000000 ^ (32'(idx) * 32'h01010101);
    endfunction

    // ---------------- backing memory (environment) ----------------
    logic [31:0]      env_mem [2][256];
    bit               env_wr  [2][256];
    logic [1:0][31:0] pipe0, pipe1;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_en[k] && mem_we[k]) begin
                env_mem[k][mem_addr[k][9:2]] <= mem_wdata[k];
                env_wr[k][mem_addr[k][9:2]]  <= 1'b1;
            end
            if (mem_en[k] && !mem_we[k])
                pipe0[k] <= env_wr[k][mem_addr[k][9:2]] ? env_mem[k][mem_addr[k][9:2]]
                                                        : init_val(int'(mem_addr[k][9:2]));
            else
                pipe0[k] <= $urandom;
            pipe1[k] <= pipe0[k];
        end
    end
    // Data appears exactly MEM_LATENCY cycles after the enable cycle; junk otherwise.
    assign mem_rdata = {pipe0[1], pipe1[0]};

    // ---------------- reference model ----------------
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          free_at [2];
    bit          last_d  [2];
    bit          pend    [2];
    int          resp_at [2];
    bit          resp_d  [2];
    logic [31:0] resp_data [2];
    logic [31:0] ref_mem [2][256];
    bit          ref_wr  [2][256];
    bit          eg_i [2];
    bit          eg_d [2];

    task automatic chk1(string tag, int k, logic got, logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL u%0d c%0d %s got=%b exp=%b", k, cyc, tag, got, exp);
        end
    endtask

    task automatic chk32(string tag, int k, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL u%0d c%0d %s got=%h exp=%h", k, cyc, tag, got, exp);
        end
    endtask

    // Predict and check every output of both instances for the current cycle.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            bit          ei, ed, en, ewe, eb, evi, evd;
            logic [31:0] ea, ew, eri, erd;
            int          idx;
            ei = 0; ed = 0; en = 0; ewe = 0; eb = 0; evi = 0; evd = 0;
            ea = '0; ew = '0; eri = '0; erd = '0;
            if (!rst) begin
                pend[k]    = 0;
                last_d[k]  = 1;
                free_at[k] = 0;
            end else begin
                eb = (cyc < free_at[k]);
                if (!eb) begin
                    if (i_req[k] && d_req[k]) begin
                        ed = !last_d[k];
                        ei = last_d[k];
                    end else begin
                        ei = i_req[k];
                        ed = d_req[k];
                    end
                end
                en  = ei | ed;
                ea  = ed ? d_addr[k] : (ei ? i_addr[k] : 32'h0);
                ewe = ed & d_we[k];
                ew  = ed ? d_wdata[k] : 32'h0;
                if (pend[k] && cyc == resp_at[k]) begin
                    evi = !resp_d[k];
                    evd = resp_d[k];
                    eri = evi ? resp_data[k] : 32'h0;
                    erd = evd ? resp_data[k] : 32'h0;
                    pend[k] = 0;
                end
                if (en) begin
                    last_d[k]  = ed;
                    free_at[k] = cyc + lat(k) + 1;
                    resp_at[k] = cyc + lat(k);
                    resp_d[k]  = ed;
                    pend[k]    = 1;
                    idx = int'(ea[9:2]);
                    if (ewe) begin
                        ref_mem[k][idx] = d_wdata[k];
                        ref_wr[k][idx]  = 1;
                        resp_data[k]    = 32'h0;
                    end else begin
                        resp_data[k] = ref_wr[k][idx] ? ref_mem[k][idx] : init_val(idx);
                    end
                end
            end
            eg_i[k] = ei;
            eg_d[k] = ed;
            chk1("i_gnt", k, i_gnt[k], ei);
            chk1("d_gnt", k, d_gnt[k], ed);
            chk1("mem_en", k, mem_en[k], en);
            if (en) chk1("mem_we", k, mem_we[k], ewe);
            chk32("mem_addr", k, mem_addr[k], ea);
            chk32("mem_wdata", k, mem_wdata[k], ew);
            chk1("i_rvalid", k, i_rvalid[k], evi);
            chk1("d_rvalid", k, d_rvalid[k], evd);
            chk32("i_rdata", k, i_rdata[k], eri);
            chk32("d_rdata", k, d_rdata[k], erd);
            chk1("busy", k, busy[k], eb);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'(($urandom_range(15) + 60) * 4);
    endfunction

    // Requesters hold until granted, occasionally withdraw, or re-request right after a grant.
    task automatic rand_reqs();
        for (int k = 0; k < 2; k++) begin
            if (i_req[k] && !eg_i[k]) begin
                if ($urandom_range(7) == 0) i_req[k] = 1'b0;
            end else begin
                i_req[k]  = ($urandom_range(2) != 0);
                i_addr[k] = rand_addr();
            end
            if (d_req[k] && !eg_d[k]) begin
                if ($urandom_range(7) == 0) d_req[k] = 1'b0;
            end else begin
                d_req[k]   = ($urandom_range(2) != 0);
                d_we[k]    = 1'($urandom_range(1));
                d_addr[k]  = rand_addr();
                d_wdata[k] = $urandom;
            end
        end
    endtask

    // Run the response window of a single access, checking the owner's data.
    task automatic resp_window(bit dside, logic [31:0] data);
        for (int off = 1; off <= 2; off++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                if (off == lat(k)) begin
                    chk1(dside ? "dir_d_rvalid" : "dir_i_rvalid", k,
                         dside ? d_rvalid[k] : i_rvalid[k], 1'b1);
                    chk32(dside ? "dir_d_rdata" : "dir_i_rdata", k,
                          dside ? d_rdata[k] : i_rdata[k], data);
                end
            end
            adv();
        end
        sample();
        for (int k = 0; k < 2; k++) chk1("dir_idle_busy", k, busy[k], 1'b0);
        adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_req = '0; d_req = '0; d_we = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        rst = 1'b0;

        // Reset held with a pending I request: everything quiet.
        i_req  = 2'b11;
        i_addr = {32'h100, 32'h100};
        repeat (3) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                chk1("rst_busy", k, busy[k], 1'b0);
                chk1("rst_i_gnt", k, i_gnt[k], 1'b0);
                chk1("rst_mem_en", k, mem_en[k], 1'b0);
            end
            adv();
        end

        // Release: the held I read of 0x100 is granted in the first cycle.
        rst = 1'b1;
        sample();
        for (int k = 0; k < 2; k++) begin
            chk1("dir_i_gnt", k, i_gnt[k], 1'b1);
            chk1("dir_mem_en", k, mem_en[k], 1'b1);
            chk1("dir_mem_we", k, mem_we[k], 1'b0);
            chk32("dir_mem_addr", k, mem_addr[k], 32'h100);
        end
        adv();
        i_req = 2'b00;
        resp_window(1'b0, 32'hDEADBEEF);

        // D write of 0x40, then read back.
        d_req = 2'b11; d_we = 2'b11;
        d_addr = {32'h40, 32'h40}; d_wdata = {32'h12345678, 32'h12345678};
        sample();
        for (int k = 0; k < 2; k++) begin
            chk1("dir_d_gnt", k, d_gnt[k], 1'b1);
            chk1("dir_wr_we", k, mem_we[k], 1'b1);
            chk32("dir_wr_wdata", k, mem_wdata[k], 32'h12345678);
        end
        adv();
        d_req = 2'b00;
        resp_window(1'b1, 32'h0);
        d_req = 2'b11; d_we = 2'b00;
        sample();
        adv();
        d_req = 2'b00;
        resp_window(1'b1, 32'h12345678);

        // Contention straight out of reset: I, D, I, D every MEM_LATENCY+1 cycles.
        rst = 1'b0;
        sample();
        adv();
        rst = 1'b1;
        i_req = 2'b11; d_req = 2'b11; d_we = 2'b00;
        i_addr = {32'h104, 32'h104}; d_addr = {32'h108, 32'h108};
        for (int c = 0; c < 12; c++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                int p;
                p = lat(k) + 1;
                chk1("rr_i_gnt", k, i_gnt[k], (c % p == 0) && ((c / p) % 2 == 0));
                chk1("rr_d_gnt", k, d_gnt[k], (c % p == 0) && ((c / p) % 2 == 1));
                if (c % p == lat(k)) begin
                    chk1("rr_i_rvalid", k, i_rvalid[k], (c / p) % 2 == 0);
                    chk1("rr_d_rvalid", k, d_rvalid[k], (c / p) % 2 == 1);
                end
            end
            adv();
        end
        i_req = 2'b00; d_req = 2'b00;
        repeat (3) begin sample(); adv(); end

        // Reset one cycle into an I read: the response must never appear.
        i_req = 2'b11; i_addr = {32'h10C, 32'h10C};
        sample();
        adv();
        i_req = 2'b00;
        rst = 1'b0;
        repeat (2) begin
            sample();
            for (int k = 0; k < 2; k++) chk1("abort_i_rvalid", k, i_rvalid[k], 1'b0);
            adv();
        end
        rst = 1'b1;
        i_req = 2'b11; d_req = 2'b11;
        sample();
        for (int k = 0; k < 2; k++) begin
            chk1("abort_tie_i", k, i_gnt[k], 1'b1);
            chk1("abort_tie_d", k, d_gnt[k], 1'b0);
        end
        adv();
        i_req = 2'b00; d_req = 2'b00;
        repeat (3) begin sample(); adv(); end

        // Request withdrawn while the arbiter is busy: no memory access results.
        d_req = 2'b11; d_we = 2'b11; d_addr = {32'h44, 32'h44}; d_wdata = {32'hA5A5A5A5, 32'hA5A5A5A5};
        sample();
        adv();
        d_req = 2'b00; i_req = 2'b11; i_addr = {32'h110, 32'h110};
        sample();
        for (int k = 0; k < 2; k++) chk1("wd_mem_en_busy", k, mem_en[k], 1'b0);
        adv();
        i_req = 2'b00;
        repeat (4) begin
            sample();
            for (int k = 0; k < 2; k++) chk1("wd_mem_en_idle", k, mem_en[k], 1'b0);
            adv();
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rand_reqs();
            sample();
            adv();
        end
        i_req = 2'b00; d_req = 2'b00;
        repeat (5) begin sample(); adv(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/backing_mem_arbiter.md
Name: backing_mem_arbiter

Overview:
- Shares the single-ported backing memory between two requesters: the instruction-fetch side (I) and the data-cache refill/write-through side (D).
- Sits between the pipeline front end / data cache and the backing memory.
- Sequences every access with a fixed-latency FSM and returns each response to the requester that owns it.
- Two-way round-robin arbitration ensures neither side starves.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- MEM_LATENCY, 2, cycles from the memory-enable cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset (clears all state while 0)
- i_req  in  1  I-side read request; held with i_addr until i_gnt
- i_addr  in  ADDR_WIDTH  I-side address
- i_gnt  out  1  I request accepted this cycle
- i_rvalid  out  1  I read data valid (1-cycle pulse)
- i_rdata  out  DATA_WIDTH  I read data
- d_req  in  1  D-side request; held with d_we, d_addr and d_wdata until d_gnt
- d_we  in  1  D-side write (1) or read (0)
- d_addr  in  ADDR_WIDTH  D-side address
- d_wdata  in  DATA_WIDTH  D-side write data
- d_gnt  out  1  D request accepted this cycle
- d_rvalid  out  1  D read data valid, or write-complete pulse
- d_rdata  out  DATA_WIDTH  D read data
- mem_en  out  1  memory access strobe (1 cycle)
- mem_we  out  1  memory write enable; qualified by mem_en
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in any state other than ARB_IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=ARB_IDLE, last_owner=OWNER_D, counter=0.
  - All outputs 0: gnt, rvalid, mem_*, rdata, busy.
  - An access in flight is abandoned; no rvalid is ever produced for it.
- FSM states: ARB_IDLE, ARB_WAIT, ARB_RESP.
- ARB_IDLE:
  - Grant logic is combinational from req.
  - Only one req high: grant that requester.
  - Both high: grant the side that is not last_owner.
  - In the grant cycle T:
    - gnt=1 for the winner.
    - mem_en=1; mem_addr, mem_we and mem_wdata driven from the winner (mem_we=0 for I).
    - owner and op latched; last_owner updated.
    - counter loaded with MEM_LATENCY-1.
  - Next state: ARB_WAIT if MEM_LATENCY>1, else ARB_RESP.
- ARB_WAIT: counter decrements each cycle; go to ARB_RESP when counter reaches 1. Never grant in this state.
- ARB_RESP, cycle T+MEM_LATENCY:
  - Owner's rvalid=1 and owner's rdata=mem_rdata (passed through combinationally).
  - For a D write: d_rvalid=1 and d_rdata=0.
  - Non-owner rvalid=0. Next state: ARB_IDLE.
- Throughput: at most one access per MEM_LATENCY+1 cycles. Earliest next grant is T+MEM_LATENCY+1.
- Requester rules:
  - A requester may drop req before gnt; no access results.
  - req held high after gnt is treated as a new request in the next ARB_IDLE.
- Outside grant cycles: mem_en=0 and mem_addr/mem_wdata=0. rdata outputs are 0 whenever rvalid=0.
- Both requesting continuously: grants alternate I, D, I, D, ... The first tie after reset goes to I.
- Counter width is $clog2(MEM_LATENCY+1). No wrap-around is possible because the counter only counts down from MEM_LATENCY-1.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_WAIT, ARB_RESP}
  - typedef enum owner_t {OWNER_I, OWNER_D}
  - localparam MAX_MEM_LATENCY=15
- One sub-module: rr_arbiter2.
  - Combinational grant from the two reqs plus last_owner.
  - Registered last_owner update, enabled by accept.

Test Plan:
- Reset: hold rst=0 for 3 cycles with i_req=1 -> all outputs 0, busy=0. Release rst -> i_gnt=1 in the first cycle.
- Single I read, MEM_LATENCY=2, i_addr=0x100, memory holds 0xDEADBEEF:
  - Cycle T: i_gnt=1, mem_en=1, mem_addr=0x100, mem_we=0.
  - Cycle T+2: i_rvalid=1, i_rdata=0xDEADBEEF.
  - Cycle T+3: idle.
- D write d_addr=0x40, d_wdata=0x12345678:
  - At grant: mem_we=1, mem_wdata=0x12345678.
  - Cycle T+2: d_rvalid=1, d_rdata=0.
  - A subsequent D read of 0x40 returns 0x12345678.
- Contention, i_req=d_req=1 held for 12 cycles after reset -> grants at cycles 0, 3, 6, 9 in order I, D, I, D. Each rvalid goes only to its owner.
- Reset mid-access: assert rst=0 at T+1 during an I read -> no i_rvalid. After release, state is ARB_IDLE and last_owner=OWNER_D.
- MEM_LATENCY=1 build: grant at T, rvalid at T+1, next grant possible at T+2. Request withdrawn before grant -> mem_en never asserted.
